// File: rtl/global_buffer_pingpong_pkg.sv
// Shared definitions for the ping/pong feature-map buffer: default geometry,
// half-select encoding and the deepest supported read pipeline.
package global_buffer_pingpong_pkg;

    localparam int K_CHANNELS      = 6;
    localparam int INT_WIDTH       = 8;
    localparam int SRAM_DEPTH      = 16;
    localparam int GB_MAX_READ_LAT = 2;

    typedef enum logic {
        HALF_PING = 1'b0,
        HALF_PONG = 1'b1
    } half_sel_e;

    function automatic half_sel_e half_flip(input half_sel_e h);
        return (h == HALF_PING) ? HALF_PONG : HALF_PING;
    endfunction

endpackage

// File: rtl/gb_bank_2p.sv
// One buffer bank: both halves in a single array addressed {half, addr},
// registered read with optional second output stage, data forced to zero when not valid.
module gb_bank_2p
    import global_buffer_pingpong_pkg::*;
#(
    parameter int DATA_W   = INT_WIDTH,
    parameter int DEPTH    = SRAM_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int READ_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_async_n_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W:0]   wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W:0]   rd_addr_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o
);

    // Sized to the full {half, addr} space so every address form stays in range.
    localparam int MEM_WORDS = 2 ** (ADDR_W + 1);

    logic [DATA_W-1:0] r_mem [MEM_WORDS];
    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;

    // Storage write port; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
    end

    // First read stage: sample the array, zero the data on idle cycles.
    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= rd_en_i;
            r_s1_data  <= rd_en_i ? r_mem[rd_addr_i] : '0;
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              r_s2_valid;
            logic [DATA_W-1:0] r_s2_data;

            // Extra output register stage for the two-cycle configuration.
            always_ff @(posedge clk_i or negedge rst_async_n_i) begin
                if (!rst_async_n_i) begin
                    r_s2_valid <= 1'b0;
                    r_s2_data  <= '0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    r_s2_data  <= r_s1_data;
                end
            end

            assign rd_valid_o = r_s2_valid;
            assign rd_data_o  = r_s2_data;
        end else begin : g_lat1
            assign rd_valid_o = r_s1_valid;
            assign rd_data_o  = r_s1_data;
        end
    endgenerate

endmodule

// File: rtl/global_buffer_pingpong.sv
// Ping/pong banked activation buffer: tracks which half is being filled and which
// is being drained, and swaps halves on the producer/consumer done handshakes.
module global_buffer_pingpong
    import global_buffer_pingpong_pkg::*;
#(
    parameter int NUM_BANKS = K_CHANNELS,
    parameter int DATA_W    = INT_WIDTH,
    parameter int DEPTH     = SRAM_DEPTH,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int READ_LAT  = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_async_n_i,
    input  logic [NUM_BANKS-1:0]              wr_en_i,
    input  logic [NUM_BANKS-1:0][ADDR_W-1:0]  wr_addr_i,
    input  logic [NUM_BANKS-1:0][DATA_W-1:0]  wr_data_i,
    input  logic                              wr_done_i,
    output logic                              wr_ready_o,
    input  logic [NUM_BANKS-1:0]              rd_en_i,
    input  logic [NUM_BANKS-1:0][ADDR_W-1:0]  rd_addr_i,
    input  logic                              rd_done_i,
    output logic                              rd_avail_o,
    output logic [NUM_BANKS-1:0]              rd_valid_o,
    output logic [NUM_BANKS-1:0][DATA_W-1:0]  rd_data_o,
    output logic [1:0]                        fill_level_o
);

    generate
        if ((READ_LAT < 1) || (READ_LAT > GB_MAX_READ_LAT)) begin : g_bad_read_lat
            $error("global_buffer_pingpong: READ_LAT must be 1 or 2");
        end
    endgenerate

    logic [1:0] r_full;
    half_sel_e  r_wr_sel;
    half_sel_e  r_rd_sel;
    logic [1:0] w_full_nxt;
    half_sel_e  w_wr_sel_nxt;
    half_sel_e  w_rd_sel_nxt;
    logic       w_wr_ready;
    logic       w_rd_avail;
    logic       w_wr_acc;
    logic       w_rd_acc;

    assign w_wr_ready   = ~r_full[r_wr_sel];
    assign w_rd_avail   = r_full[r_rd_sel];
    assign w_wr_acc     = wr_done_i & w_wr_ready;
    assign w_rd_acc     = rd_done_i & w_rd_avail;
    assign wr_ready_o   = w_wr_ready;
    assign rd_avail_o   = w_rd_avail;
    assign fill_level_o = {1'b0, r_full[0]} + {1'b0, r_full[1]};

    // Half hand-over; accepted done pulses always target different halves.
    always_comb begin
        w_full_nxt   = r_full;
        w_wr_sel_nxt = r_wr_sel;
        w_rd_sel_nxt = r_rd_sel;
        if (w_wr_acc) begin
            w_full_nxt[r_wr_sel] = 1'b1;
            w_wr_sel_nxt         = half_flip(r_wr_sel);
        end else begin
            w_wr_sel_nxt = r_wr_sel;
        end
        if (w_rd_acc) begin
            w_full_nxt[r_rd_sel] = 1'b0;
            w_rd_sel_nxt         = half_flip(r_rd_sel);
        end else begin
            w_rd_sel_nxt = r_rd_sel;
        end
    end

    // Full flags and half pointers.
    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            r_full   <= 2'b00;
            r_wr_sel <= HALF_PING;
            r_rd_sel <= HALF_PING;
        end else begin
            r_full   <= w_full_nxt;
            r_wr_sel <= w_wr_sel_nxt;
            r_rd_sel <= w_rd_sel_nxt;
        end
    end

    generate
        for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
            gb_bank_2p #(
                .DATA_W   (DATA_W),
                .DEPTH    (DEPTH),
                .ADDR_W   (ADDR_W),
                .READ_LAT (READ_LAT)
            ) u_bank (
                .clk_i         (clk_i),
                .rst_async_n_i (rst_async_n_i),
                .wr_en_i       (wr_en_i[k] & w_wr_ready),
                .wr_addr_i     ({r_wr_sel, wr_addr_i[k]}),
                .wr_data_i     (wr_data_i[k]),
                .rd_en_i       (rd_en_i[k] & w_rd_avail),
                .rd_addr_i     ({r_rd_sel, rd_addr_i[k]}),
                .rd_valid_o    (rd_valid_o[k]),
                .rd_data_o     (rd_data_o[k])
            );
        end
    endgenerate

endmodule

// File: tb/tb_global_buffer_pingpong.sv
// Bench for global_buffer_pingpong: one READ_LAT=1 and one READ_LAT=2 instance share
// stimulus; both are compared every cycle against a frame-level reference model.
module tb_global_buffer_pingpong;

    localparam int NB = 6;
    localparam int DW = 8;
    localparam int DP = 16;
    localparam int AW = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NB-1:0]        wr_en, rd_en;
    logic [NB-1:0][AW-1:0] wr_addr, rd_addr;
    logic [NB-1:0][DW-1:0] wr_data;
    logic                 wr_done, rd_done;

    logic                  wr_ready1, rd_avail1, wr_ready2, rd_avail2;
    logic [NB-1:0]         valid1, valid2;
    logic [NB-1:0][DW-1:0] data1, data2;
    logic [1:0]            fill1, fill2;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: frame contents per half, full flags, half pointers,
    // and the read results seen one and two cycles after request.
    logic [DW-1:0]         mdl_mem [2][NB][DP];
    logic [1:0]            mdl_full;
    int                    mdl_wp, mdl_rp;
    logic [NB-1:0]         cur_v, prev_v;
    logic [NB-1:0][DW-1:0] cur_d, prev_d;

    always #5 clk = ~clk;

    global_buffer_pingpong #(.NUM_BANKS(NB), .DATA_W(DW), .DEPTH(DP), .READ_LAT(1)) u_dut_lat1 (
        .clk_i(clk), .rst_async_n_i(rst_n),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_done_i(wr_done),
        .wr_ready_o(wr_ready1),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_done_i(rd_done), .rd_avail_o(rd_avail1),
        .rd_valid_o(valid1), .rd_data_o(data1), .fill_level_o(fill1)
    );

    global_buffer_pingpong #(.NUM_BANKS(NB), .DATA_W(DW), .DEPTH(DP), .READ_LAT(2)) u_dut_lat2 (
        .clk_i(clk), .rst_async_n_i(rst_n),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_done_i(wr_done),
        .wr_ready_o(wr_ready2),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_done_i(rd_done), .rd_avail_o(rd_avail2),
        .rd_valid_o(valid2), .rd_data_o(data2), .fill_level_o(fill2)
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_full = 2'b00;
        mdl_wp   = 0;
        mdl_rp   = 0;
        cur_v    = '0;
        prev_v   = '0;
        cur_d    = '0;
        prev_d   = '0;
    endtask

    task automatic model_step();
        logic [NB-1:0]         nv;
        logic [NB-1:0][DW-1:0] nd;
        logic                  wr_ok, rd_ok;
        wr_ok = !mdl_full[mdl_wp];
        rd_ok = mdl_full[mdl_rp];
        nv = '0;
        nd = '0;
        for (int k = 0; k < NB; k++) begin
            if (rd_en[k] && rd_ok) begin
                nv[k] = 1'b1;
                nd[k] = mdl_mem[mdl_rp][k][rd_addr[k]];
            end
            if (wr_en[k] && wr_ok) mdl_mem[mdl_wp][k][wr_addr[k]] = wr_data[k];
        end
        if (wr_done && wr_ok) begin
            mdl_full[mdl_wp] = 1'b1;
            mdl_wp = 1 - mdl_wp;
        end
        if (rd_done && rd_ok) begin
            mdl_full[mdl_rp] = 1'b0;
            mdl_rp = 1 - mdl_rp;
        end
        prev_v = cur_v;
        prev_d = cur_d;
        cur_v  = nv;
        cur_d  = nd;
    endtask

    task automatic check_outputs();
        logic [63:0] exp_fill;
        exp_fill = 64'(mdl_full[0]) + 64'(mdl_full[1]);
        chk_eq("lat1_valid", 64'(valid1), 64'(cur_v));
        chk_eq("lat1_data", 64'(data1), 64'(cur_d));
        chk_eq("lat2_valid", 64'(valid2), 64'(prev_v));
        chk_eq("lat2_data", 64'(data2), 64'(prev_d));
        chk_eq("lat1_wr_ready", 64'(wr_ready1), 64'(!mdl_full[mdl_wp]));
        chk_eq("lat2_wr_ready", 64'(wr_ready2), 64'(!mdl_full[mdl_wp]));
        chk_eq("lat1_rd_avail", 64'(rd_avail1), 64'(mdl_full[mdl_rp]));
        chk_eq("lat2_rd_avail", 64'(rd_avail2), 64'(mdl_full[mdl_rp]));
        chk_eq("lat1_fill", 64'(fill1), exp_fill);
        chk_eq("lat2_fill", 64'(fill2), exp_fill);
    endtask

    task automatic idle();
        wr_en   = '0;
        rd_en   = '0;
        wr_addr = '0;
        rd_addr = '0;
        wr_data = '0;
        wr_done = 1'b0;
        rd_done = 1'b0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // mode 0: 16*k+a, 1: 0x60+16*k+a, 2: a, 3: random; then a done cycle.
    task automatic write_frame(input int mode, input logic do_rd_done);
        for (int a = 0; a < DP; a++) begin
            idle();
            wr_en = '1;
            for (int k = 0; k < NB; k++) begin
                wr_addr[k] = 4'(a);
                case (mode)
                    0:       wr_data[k] = 8'(16 * k + a);
                    1:       wr_data[k] = 8'(8'h60 + 16 * k + a);
                    2:       wr_data[k] = 8'(a);
                    default: wr_data[k] = 8'($urandom);
                endcase
            end
            tick();
        end
        idle();
        wr_done = 1'b1;
        rd_done = do_rd_done;
        tick();
    endtask

    initial begin
        idle();
        model_reset();
        #12;
        check_outputs();
        chk_eq("reset_wr_ready", 64'(wr_ready1), 64'd1);
        rst_n = 1'b1;
        idle();
        tick();

        // 1: first frame into ping, single-bank read
        write_frame(0, 1'b0);
        chk_eq("t1_fill", 64'(fill1), 64'd1);
        chk_eq("t1_wr_ready", 64'(wr_ready1), 64'd1);
        chk_eq("t1_rd_avail", 64'(rd_avail1), 64'd1);
        idle();
        rd_en = 6'b000100;
        rd_addr[2] = 4'd5;
        tick();
        chk_eq("t1_valid", 64'(valid1), 64'h04);
        chk_eq("t1_bank2", 64'(data1[2]), 64'h25);
        chk_eq("t1_others", 64'(data1) & ~64'h0000_0000_00FF_0000, 64'd0);

        // 2: both halves full, dropped write, then pong still original
        write_frame(1, 1'b0);
        chk_eq("t2_fill", 64'(fill1), 64'd2);
        chk_eq("t2_wr_ready", 64'(wr_ready1), 64'd0);
        idle();
        wr_en = '1;
        wr_data = {NB{8'hFF}};
        tick();
        idle();
        rd_done = 1'b1;
        tick();
        idle();
        rd_en = '1;
        tick();
        chk_eq("t2_pong_addr0", 64'(data1), 64'hB0A0_9080_7060);

        // 3: simultaneous done pulses keep the fill level
        write_frame(3, 1'b1);
        chk_eq("t3_fill_a", 64'(fill1), 64'd1);
        write_frame(2, 1'b1);
        chk_eq("t3_fill_b", 64'(fill1), 64'd1);

        // 4: back-to-back reads on the two-cycle instance, done right after
        idle();
        rd_en = '1;
        rd_addr = {NB{4'd3}};
        tick();
        chk_eq("t4_lat2_idle", 64'(valid2), 64'd0);
        rd_addr = {NB{4'd4}};
        tick();
        chk_eq("t4_d3", 64'(data2), 64'h0303_0303_0303);
        rd_addr = {NB{4'd5}};
        tick();
        chk_eq("t4_d4", 64'(data2), 64'h0404_0404_0404);
        idle();
        rd_done = 1'b1;
        tick();
        chk_eq("t4_d5", 64'(data2), 64'h0505_0505_0505);
        chk_eq("t4_v5", 64'(valid2), 64'h3F);
        chk_eq("t4_fill", 64'(fill1), 64'd0);
        idle();
        tick();
        chk_eq("t4_drained", 64'(valid2), 64'd0);

        // 5: read and done while empty are ignored
        rd_en = '1;
        rd_done = 1'b1;
        tick();
        idle();
        tick();
        chk_eq("t5_valid1", 64'(valid1), 64'd0);
        chk_eq("t5_valid2", 64'(valid2), 64'd0);
        chk_eq("t5_fill", 64'(fill1), 64'd0);
        chk_eq("t5_wr_ready", 64'(wr_ready1), 64'd1);

        // random traffic against the model
        for (int c = 0; c < 400; c++) begin
            wr_en   = 6'($urandom);
            rd_en   = 6'($urandom);
            for (int k = 0; k < NB; k++) begin
                wr_addr[k] = 4'($urandom);
                rd_addr[k] = 4'($urandom);
                wr_data[k] = 8'($urandom);
            end
            wr_done = ($urandom_range(0, 5) == 0);
            rd_done = ($urandom_range(0, 5) == 0);
            tick();
        end

        // 6: asynchronous reset between edges with reads in flight
        idle();
        if (mdl_full == 2'b00) begin
            wr_done = 1'b1;
            tick();
            idle();
        end
        rd_en = '1;
        for (int k = 0; k < NB; k++) rd_addr[k] = 4'($urandom);
        tick();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk_eq("t6_valid1", 64'(valid1), 64'd0);
        chk_eq("t6_data2", 64'(data2), 64'd0);
        chk_eq("t6_fill", 64'(fill1), 64'd0);
        chk_eq("t6_wr_ready", 64'(wr_ready2), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        chk_eq("t6_no_stale", 64'(valid2), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
